// File: rtl/haz_pkg.sv
// Shared types and helpers for the hazard scoreboard: entry record, "unused operand"
// code, register-file forward select and saturating Tnew decrement.
package haz_pkg;

    // Entry fields are held at a maximum width; narrower instances zero-extend,
    // and the constant upper bits are trimmed away in synthesis.
    localparam int AW_MAX = 8;
    localparam int TW_MAX = 4;

    localparam logic [TW_MAX-1:0] TUSE_NONE = '1;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic              valid;
        logic [AW_MAX-1:0] addr;
        logic [TW_MAX-1:0] tnew;
    } haz_entry_t;

    function automatic logic [TW_MAX-1:0] sat_dec(input logic [TW_MAX-1:0] t);
        return (t == '0) ? '0 : t - TW_MAX'(1);
    endfunction

endpackage

// File: rtl/haz_match.sv
// Youngest-match finder: scans the tracked entries for one source operand and reports
// the lowest-index valid entry writing that register (register 0 never matches).
import haz_pkg::*;

module haz_match #(
    parameter int NSTAGE = 3,
    parameter int SELW   = 2
) (
    input  haz_entry_t [NSTAGE-1:0] entries,
    input  logic [AW_MAX-1:0]       operand,
    output logic                    hit,
    output logic [SELW-1:0]         idx,
    output logic [TW_MAX-1:0]       tnew
);

    // Scan oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        tnew = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (entries[k].valid && (entries[k].addr == operand) && (operand != '0)) begin
                hit  = 1'b1;
                idx  = SELW'(k);
                tnew = entries[k].tnew;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard unit: tracks destination registers in E..W, produces the D-stage
// stall and forward selects. Define HAZ_STAT_EN to add stall/forward cycle counters.
import haz_pkg::*;

module hazard_scoreboard #(
    parameter int NSTAGE = 3,
    parameter int AW     = 5,
    parameter int TW     = 2,
    parameter int SELW   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     d_rs,
    input  logic [AW-1:0]     d_rt,
    input  logic [TW-1:0]     d_tuse_rs,
    input  logic [TW-1:0]     d_tuse_rt,
    input  logic              d_wr_en,
    input  logic [AW-1:0]     d_wr_addr,
    input  logic [TW-1:0]     d_tnew,
    input  logic              flush,
    input  logic              freeze,
    output logic              stall,
    output logic [SELW-1:0]   fwd_sel_rs,
    output logic [SELW-1:0]   fwd_sel_rt,
    output logic [NSTAGE-1:0] stage_valid
`ifdef HAZ_STAT_EN
   ,output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt
`endif
);

    haz_entry_t [NSTAGE-1:0] ent;

    logic              hit_rs, hit_rt;
    logic [SELW-1:0]   idx_rs, idx_rt;
    logic [TW_MAX-1:0] tnew_rs, tnew_rt;
    logic              stall_rs, stall_rt;

    haz_match #(.NSTAGE(NSTAGE), .SELW(SELW)) u_match_rs (
        .entries (ent),
        .operand (AW_MAX'(d_rs)),
        .hit     (hit_rs),
        .idx     (idx_rs),
        .tnew    (tnew_rs)
    );

    haz_match #(.NSTAGE(NSTAGE), .SELW(SELW)) u_match_rt (
        .entries (ent),
        .operand (AW_MAX'(d_rt)),
        .hit     (hit_rt),
        .idx     (idx_rt),
        .tnew    (tnew_rt)
    );

    always_comb begin
        stall_rs   = (d_tuse_rs != TW'(TUSE_NONE)) && hit_rs && (tnew_rs > TW_MAX'(d_tuse_rs));
        stall_rt   = (d_tuse_rt != TW'(TUSE_NONE)) && hit_rt && (tnew_rt > TW_MAX'(d_tuse_rt));
        stall      = stall_rs || stall_rt;
        fwd_sel_rs = (hit_rs && (tnew_rs == '0)) ? idx_rs + SELW'(1) : SELW'(FWD_RF);
        fwd_sel_rt = (hit_rt && (tnew_rt == '0)) ? idx_rt + SELW'(1) : SELW'(FWD_RF);
    end

    always_comb begin
        stage_valid = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            stage_valid[k] = ent[k].valid;
        end
    end

    // A stalled D instruction stays put, so a bubble enters E instead of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent <= '0;
        end else if (flush) begin
            for (int k = 0; k < NSTAGE; k++) begin
                ent[k].valid <= 1'b0;
            end
        end else if (!freeze) begin
            for (int k = 1; k < NSTAGE; k++) begin
                ent[k] <= '{valid: ent[k-1].valid,
                            addr:  ent[k-1].addr,
                            tnew:  sat_dec(ent[k-1].tnew)};
            end
            if (stall) begin
                ent[0] <= '0;
            end else begin
                ent[0] <= '{valid: d_wr_en && (d_wr_addr != '0),
                            addr:  AW_MAX'(d_wr_addr),
                            tnew:  TW_MAX'(d_tnew)};
            end
        end
    end

`ifdef HAZ_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && !freeze) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if ((fwd_sel_rs != '0) || (fwd_sel_rt != '0)) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the MIPS pipeline.
- Tracks one destination-register entry per stage downstream of Decode (E, M, W by default), each with a Tnew countdown.
- Compares the Decode instruction's source registers and Tuse against those entries.
- Produces the D-stage stall, the bubble insert and the D-stage forward selects.
- Stage count, register-address width and timing width are generic, and a flush/freeze interface is added. Hard-coded per-stage class decoding is no longer needed.

Parameters:
- NSTAGE, 3, tracked stages after D (index 0 = E, NSTAGE-1 = W)
- AW, 5, register address width
- TW, 2, Tuse/Tnew width; all-ones Tuse = "operand not used"
- SELW, 2, forward-select width; must satisfy 2^SELW > NSTAGE

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- d_rs  in  AW  D-stage source A address
- d_rt  in  AW  D-stage source B address
- d_tuse_rs  in  TW  cycles until rs is needed; all-ones = unused
- d_tuse_rt  in  TW  same for rt
- d_wr_en  in  1  D instruction writes a register
- d_wr_addr  in  AW  destination address
- d_tnew  in  TW  cycles after entering E until the result is forwardable
- flush  in  1  exception/eret: kill all tracked entries
- freeze  in  1  whole-pipe hold (memory wait)
- stall  out  1  hold F/D, insert bubble into E
- fwd_sel_rs  out  SELW  0 = register file, k+1 = forward from stage k
- fwd_sel_rt  out  SELW  same for rt
- stage_valid  out  NSTAGE  per-stage write-pending flags, for debug

Behaviour:
- Entry k holds {valid, addr, tnew}. The register is asynchronously cleared when rst_n = 0: all valid = 0, addr = 0, tnew = 0.
- Reset output values: stall = 0, fwd_sel_* = 0, stage_valid = 0.
- Clock-edge advance (freeze = 0, flush = 0):
  - entry[k+1] <= {entry[k].valid, entry[k].addr, sat_dec(entry[k].tnew)}, where sat_dec stops at 0.
  - entry[0] <= stall ? bubble (valid = 0) : {d_wr_en & (d_wr_addr != 0), d_wr_addr, d_tnew}.
  - The W entry falls off the end.
- freeze = 1: all entries hold. stall and fwd outputs are still computed combinationally from the held state.
- flush = 1: all valid cleared next edge. flush takes priority over freeze and over the advance.
- Match rule per operand: only entries with valid, addr == operand and operand != 0 count.
  - The youngest (lowest k) match wins; older matches are ignored.
- Stall condition: stall = OR over rs, rt of (tuse != all-ones) & match & (tnew_youngest > tuse). It is purely combinational, with zero-cycle latency.
- Forward select: if the youngest match has tnew == 0, sel = k+1; otherwise sel = 0.
  - A nonzero-tnew match that does not stall resolves via downstream forwarding, outside this block.
- A stall with d_tnew on the held instruction does not alter entries other than the bubble insert.
- Register 0 is never tracked or forwarded.
- Simultaneous rs == rt: both selects are evaluated independently with identical results.
- Reset mid-operation clears state immediately (asynchronous). Outputs go to 0 in the same cycle, since they derive only from the cleared entries.

Optional Feature:
- HAZ_STAT_EN defined: adds output stall_cnt[31:0].
  - It increments each cycle with stall = 1 and freeze = 0, wraps at 2^32, and clears on reset.
  - It also adds fwd_cnt[31:0], counting cycles with any nonzero fwd_sel.
- HAZ_STAT_EN undefined: no counters and no extra ports. Logic is otherwise identical.

Decomposition:
- Shared package haz_pkg holds:
  - the entry typedef {valid, addr, tnew}
  - TUSE_NONE (all-ones)
  - the FWD_RF = 0 constant
  - the sat_dec function
- One natural sub-module, haz_match: a combinational youngest-match finder over NSTAGE entries for one operand, returning hit, stage index and tnew. It is instantiated twice (rs, rt).

Test Plan:
- Reset: rst_n = 0 mid-run with entries valid → stall = 0, fwd_sel = 0, stage_valid = 000 immediately.
- Load-use: lw $8 (tnew = 2) enters E, next D uses $8 with tuse = 0 → stall = 1 for 2 cycles. In the 3rd cycle stall = 0 and fwd_sel_rs = 3 (W).
- ALU forward: addu $5 (tnew = 1) in E, D beq with tuse = 0 on $5 → 1 stall. Then fwd_sel_rs = 2 (M), stall = 0.
- Youngest wins: $9 written by entries in both E (tnew = 0) and W (tnew = 0) → fwd_sel = 1.
- $0 write with tnew = 3 followed by a use of $0 → stall = 0, fwd_sel = 0.
- Flush while freeze = 1 with 3 valid entries → stage_valid = 000 next edge.
- With HAZ_STAT_EN defined, a load-use pair → stall_cnt = 2.
